// File: rtl/eth_idma_req_arbiter.sv
// -----------------------------------------------------------------------------
// eth_idma_pkg / eth_idma_req_arbiter
//
// Purpose: shares the single Ethernet iDMA backend between NumReq transfer
// requesters (e.g. TX and RX descriptor engines). Requests are granted
// round-robin; every granted transfer records its requester index in an
// order FIFO so that the in-order backend responses can be routed back to
// the requester that issued them.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   enable_i            allows new grants (responses are routed regardless)
//   req_i/req_valid_i   per-requester descriptor and valid
//   req_ready_o         per-requester accept
//   rsp_o               backend response, broadcast to all requesters
//   rsp_valid_o         one-hot response valid, selected by the FIFO head
//   rsp_ready_i         per-requester response ready
//   idma_req_*          request channel to the backend
//   idma_rsp_*          response channel from the backend
//   outstanding_o       transfers in flight (order FIFO count)
//   busy_o              outstanding_o != 0
//   err_o               pulse the cycle after an accepted response with error
//   spurious_o          high while a response arrives with nothing in flight
// -----------------------------------------------------------------------------
package eth_idma_pkg;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [15:0] length;
    } idma_req_t;

    typedef struct packed {
        logic [15:0] length;
        logic        error;
    } idma_rsp_t;

endpackage

module eth_idma_req_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdxWidth       = $clog2(NumReq)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    enable_i,
    input  eth_idma_pkg::idma_req_t [NumReq-1:0]    req_i,
    input  logic [NumReq-1:0]                       req_valid_i,
    output logic [NumReq-1:0]                       req_ready_o,
    output eth_idma_pkg::idma_rsp_t                 rsp_o,
    output logic [NumReq-1:0]                       rsp_valid_o,
    input  logic [NumReq-1:0]                       rsp_ready_i,
    output eth_idma_pkg::idma_req_t                 idma_req_o,
    output logic                                    idma_req_valid_o,
    input  logic                                    idma_req_ready_i,
    input  eth_idma_pkg::idma_rsp_t                 idma_rsp_i,
    input  logic                                    idma_rsp_valid_i,
    output logic                                    idma_rsp_ready_o,
    output logic [$clog2(MaxOutstanding):0]         outstanding_o,
    output logic                                    busy_o,
    output logic                                    err_o,
    output logic                                    spurious_o
);

    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned CntW = PtrW + 1;

    // Round-robin successor, wrapping modulo NumReq (NumReq need not be 2^n).
    function automatic logic [IdxWidth-1:0] next_rr(input logic [IdxWidth-1:0] idx);
        if (idx == IdxWidth'(NumReq - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Arbitration state
    logic [IdxWidth-1:0] rr_ptr_q;
    logic                lock_q;
    logic [IdxWidth-1:0] lock_idx_q;

    // Order FIFO: requester index of every transfer in flight
    logic [IdxWidth-1:0] fifo_mem_q [MaxOutstanding];
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic [CntW-1:0]     count_d;
    logic                full_q;
    logic                fifo_empty;
    logic [IdxWidth-1:0] head_idx;

    logic                err_p1;

    logic [IdxWidth-1:0] grant_idx;
    logic                grant_vld;
    int unsigned         cand;
    logic                push;
    logic                pop;

    // Grant selection. A locked grant is held unconditionally so the backend
    // sees a stable request; otherwise the cyclic search from rr_ptr_q runs
    // only when enabled and the FIFO was not full at the last edge.
    always_comb begin
        grant_idx = lock_idx_q;
        grant_vld = 1'b0;
        cand      = 0;
        if (lock_q) begin
            grant_idx = lock_idx_q;
            grant_vld = req_valid_i[lock_idx_q];
        end else if (enable_i && !full_q) begin
            for (int unsigned off = 0; off < NumReq; off++) begin
                cand = (32'(rr_ptr_q) + off) % NumReq;
                if (!grant_vld && req_valid_i[IdxWidth'(cand)]) begin
                    grant_vld = 1'b1;
                    grant_idx = IdxWidth'(cand);
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_vld) begin
            req_ready_o[grant_idx] = idma_req_ready_i;
        end
    end

    assign idma_req_o       = req_i[grant_idx];
    assign idma_req_valid_o = grant_vld;
    assign push             = grant_vld && idma_req_ready_i;

    // Response routing from the FIFO head; nothing is accepted while empty.
    assign fifo_empty = (count_q == '0);
    assign head_idx   = fifo_mem_q[rd_ptr_q];

    always_comb begin
        rsp_valid_o = '0;
        if (!fifo_empty) begin
            rsp_valid_o[head_idx] = idma_rsp_valid_i;
        end
    end

    assign idma_rsp_ready_o = !fifo_empty && rsp_ready_i[head_idx];
    assign rsp_o            = idma_rsp_i;
    assign pop              = idma_rsp_valid_i && idma_rsp_ready_o;
    assign spurious_o       = idma_rsp_valid_i && fifo_empty;

    assign count_d = count_q + CntW'(push) - CntW'(pop);

    // Control state: arbitration, FIFO pointers/count, error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            err_p1     <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr_q <= next_rr(grant_idx);
                lock_q   <= 1'b0;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end else if (grant_vld) begin
                lock_q     <= 1'b1;
                lock_idx_q <= grant_idx;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            // Registered full flag: a pop in the full cycle does not let a
            // grant through until the following cycle.
            full_q  <= (count_d == CntW'(MaxOutstanding));
            err_p1  <= pop && idma_rsp_i.error;
        end
    end

    // FIFO storage: data only, no reset needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    assign outstanding_o = count_q;
    assign busy_o        = (count_q != '0);
    assign err_o         = err_p1;

endmodule

// File: tb/tb_eth_idma_req_arbiter.sv
module tb_eth_idma_req_arbiter;

    import eth_idma_pkg::*;

    typedef struct packed {
        logic [7:0] idx;
        idma_rsp_t  rsp;
    } exp_rsp_t;

    logic                  clk;
    logic                  rst_n;
    logic                  enable;
    idma_req_t [1:0]       req;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    idma_rsp_t             rsp;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    idma_req_t             idma_req;
    logic                  idma_req_valid;
    logic                  idma_req_ready;
    idma_rsp_t             idma_rsp;
    logic                  idma_rsp_valid;
    logic                  idma_rsp_ready;
    logic [2:0]            outstanding;
    logic                  busy;
    logic                  err;
    logic                  spurious;

    int total = 0;
    int bad   = 0;

    idma_req_t exp_req [$];
    exp_rsp_t  exp_rsp [$];

    idma_req_t d0;
    idma_req_t d1;

    eth_idma_req_arbiter #(
        .NumReq         (2),
        .MaxOutstanding (4)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .enable_i         (enable),
        .req_i            (req),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .rsp_o            (rsp),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .idma_req_o       (idma_req),
        .idma_req_valid_o (idma_req_valid),
        .idma_req_ready_i (idma_req_ready),
        .idma_rsp_i       (idma_rsp),
        .idma_rsp_valid_i (idma_rsp_valid),
        .idma_rsp_ready_o (idma_rsp_ready),
        .outstanding_o    (outstanding),
        .busy_o           (busy),
        .err_o            (err),
        .spurious_o       (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input logic [7:0] idx, input logic [15:0] len, input logic e);
        exp_rsp_t x;
        x.idx = idx;
        x.rsp.length = len;
        x.rsp.error  = e;
        idma_rsp.length = len;
        idma_rsp.error  = e;
        idma_rsp_valid  = 1'b1;
        exp_rsp.push_back(x);
        tick();
    endtask

    // Scoreboard monitor: compares every handshake seen on the DUT outputs
    // against the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (idma_req_valid && idma_req_ready) begin
                if (exp_req.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL grant_unexpected got=%0h want=none", idma_req);
                end else begin
                    check("grant_desc", 128'(idma_req), 128'(exp_req.pop_front()));
                end
            end
            if ((rsp_valid & rsp_ready) != 2'b00) begin
                exp_rsp_t got;
                got.idx = (rsp_valid == 2'b01) ? 8'd0 : (rsp_valid == 2'b10) ? 8'd1 : 8'hff;
                got.rsp = rsp;
                if (exp_rsp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected got=%0h want=none", got);
                end else begin
                    check("rsp_route", 128'(got), 128'(exp_rsp.pop_front()));
                end
            end
        end
    end

    initial begin
        d0 = '{src_addr: 32'h1000_0000, dst_addr: 32'h2000_0000, length: 16'd64};
        d1 = '{src_addr: 32'h3000_0000, dst_addr: 32'h4000_0000, length: 16'd128};
        rst_n          = 1'b0;
        enable         = 1'b1;
        req[0]         = d0;
        req[1]         = d1;
        req_valid      = 2'b00;
        rsp_ready      = 2'b11;
        idma_req_ready = 1'b0;
        idma_rsp       = '0;
        idma_rsp_valid = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_outstanding", 128'(outstanding), 128'(0));
        check("rst_req_valid", 128'(idma_req_valid), 128'(0));
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_rsp_ready", 128'(idma_rsp_ready), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_spurious", 128'(spurious), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        tick();

        // Fairness: both valid, backend always ready -> 0,1,0,1
        idma_req_ready = 1'b1;
        req_valid = 2'b11;
        exp_req.push_back(d0); exp_req.push_back(d1);
        exp_req.push_back(d0); exp_req.push_back(d1);
        repeat (4) tick();
        req_valid = 2'b00;
        #1;
        check("fair_outstanding", 128'(outstanding), 128'(4));
        for (int k = 0; k < 4; k++) push_rsp(8'(k % 2), 16'(100 + k), 1'b0);
        idma_rsp_valid = 1'b0;
        #1;
        check("fair_drained", 128'(outstanding), 128'(0));
        check("fair_busy", 128'(busy), 128'(0));

        // Backpressure lock: requester 1 held while requester 0 raises valid
        idma_req_ready = 1'b0;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("lock_desc", 128'(idma_req), 128'(d1));
            check("lock_valid", 128'(idma_req_valid), 128'(1));
            check("lock_ready", 128'(req_ready), 128'(0));
            tick();
        end
        exp_req.push_back(d1);
        idma_req_ready = 1'b1;
        tick();
        exp_req.push_back(d0);
        tick();
        req_valid = 2'b00;
        #1;
        check("lock_outstanding", 128'(outstanding), 128'(2));
        push_rsp(8'd1, 16'd11, 1'b0);
        push_rsp(8'd0, 16'd12, 1'b0);
        idma_rsp_valid = 1'b0;

        // Full FIFO: four grants, fifth stalls until the cycle after a pop
        req_valid = 2'b01;
        repeat (4) exp_req.push_back(d0);
        repeat (4) tick();
        tick();
        check("full_stall", 128'(idma_req_valid), 128'(0));
        check("full_outstanding", 128'(outstanding), 128'(4));
        check("full_req_ready", 128'(req_ready), 128'(0));
        idma_rsp.length = 16'd200;
        idma_rsp.error  = 1'b0;
        idma_rsp_valid  = 1'b1;
        exp_rsp.push_back('{idx: 8'd0, rsp: '{length: 16'd200, error: 1'b0}});
        #1;
        check("full_pop_cycle", 128'(idma_req_valid), 128'(0));
        tick();
        idma_rsp_valid = 1'b0;
        #1;
        check("full_after_pop", 128'(idma_req_valid), 128'(1));
        check("full_out_3", 128'(outstanding), 128'(3));
        exp_req.push_back(d0);
        tick();
        req_valid = 2'b00;
        #1;
        check("full_refill", 128'(outstanding), 128'(4));
        for (int k = 0; k < 4; k++) push_rsp(8'd0, 16'(201 + k), 1'b0);
        idma_rsp_valid = 1'b0;

        // Error response for requester 0
        req_valid = 2'b01;
        exp_req.push_back(d0);
        tick();
        req_valid = 2'b00;
        idma_rsp.length = 16'd300;
        idma_rsp.error  = 1'b1;
        idma_rsp_valid  = 1'b1;
        exp_rsp.push_back('{idx: 8'd0, rsp: '{length: 16'd300, error: 1'b1}});
        #1;
        check("err_before", 128'(err), 128'(0));
        tick();
        idma_rsp_valid = 1'b0;
        check("err_pulse", 128'(err), 128'(1));
        tick();
        check("err_after", 128'(err), 128'(0));

        // Spurious response with nothing in flight
        idma_rsp       = '0;
        idma_rsp_valid = 1'b1;
        #1;
        check("spur_flag", 128'(spurious), 128'(1));
        check("spur_ready", 128'(idma_rsp_ready), 128'(0));
        check("spur_rsp_valid", 128'(rsp_valid), 128'(0));
        tick();
        check("spur_flag_2", 128'(spurious), 128'(1));
        check("spur_outstanding", 128'(outstanding), 128'(0));
        idma_rsp_valid = 1'b0;
        #1;
        check("spur_clear", 128'(spurious), 128'(0));

        // Drain: disable with 2 in flight and requests pending
        req_valid = 2'b11;
        exp_req.push_back(d1);
        exp_req.push_back(d0);
        repeat (2) tick();
        enable = 1'b0;
        #1;
        check("drain_no_grant", 128'(idma_req_valid), 128'(0));
        check("drain_req_ready", 128'(req_ready), 128'(0));
        tick();
        check("drain_outstanding", 128'(outstanding), 128'(2));
        check("drain_busy", 128'(busy), 128'(1));
        push_rsp(8'd1, 16'd41, 1'b0);
        push_rsp(8'd0, 16'd42, 1'b0);
        idma_rsp_valid = 1'b0;
        #1;
        check("drain_busy_low", 128'(busy), 128'(0));
        check("drain_out_0", 128'(outstanding), 128'(0));
        check("drain_still_idle", 128'(idma_req_valid), 128'(0));
        req_valid = 2'b00;
        enable = 1'b1;
        tick();

        // Reset mid-operation: 3 in flight, pointer left at 1
        req_valid = 2'b01;
        repeat (3) exp_req.push_back(d0);
        repeat (3) tick();
        req_valid = 2'b00;
        #1;
        check("mid_outstanding", 128'(outstanding), 128'(3));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", 128'(outstanding), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_req_valid", 128'(idma_req_valid), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        req_valid = 2'b11;
        #1;
        check("mid_first_grant", 128'(idma_req), 128'(d0));
        exp_req.push_back(d0);
        tick();
        req_valid = 2'b00;
        #1;
        check("mid_out_1", 128'(outstanding), 128'(1));
        push_rsp(8'd0, 16'd55, 1'b0);
        idma_rsp_valid = 1'b0;
        #1;
        check("mid_out_0", 128'(outstanding), 128'(0));

        tick();
        check("left_req", 128'(exp_req.size()), 128'(0));
        check("left_rsp", 128'(exp_rsp.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
